// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and default sizing for the elevator car controller
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS   = 4;
    localparam int DEFAULT_TRAVEL_TICKS = 8;
    localparam int DEFAULT_DOOR_TICKS   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/elevator_scheduler_tick_timer.sv
// rtl/elevator_scheduler_tick_timer.sv - tick-driven interval timer with one-cycle done strobe
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    // Count self-resets on reaching the limit, so it never exceeds limit-1.
    always_comb begin
        done    = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            if (count_q + 1'b1 == limit) begin
                done    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN-ordered elevator car controller with call latching and timed travel/dwell
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = DEFAULT_NUM_FLOORS,
    parameter int TRAVEL_TICKS = DEFAULT_TRAVEL_TICKS,
    parameter int DOOR_TICKS   = DEFAULT_DOOR_TICKS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_FLOORS-1:0]         call_req,
    output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
    output logic                          moving_up,
    output logic                          moving_down,
    output logic                          door_open,
    output logic [NUM_FLOORS-1:0]         pending
);

    localparam int FW   = $clog2(NUM_FLOORS);
    localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FW-1:0]         cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  travel_clear, door_clear;
    logic                  travel_done, door_done;
    logic                  above, below;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && p[i]) any_above = 1'b1;
        end
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && p[i]) any_below = 1'b1;
        end
    endfunction

    tick_timer #(.W(TW)) u_travel_timer (
        .clk   (clk),
        .reset (reset),
        .clear (travel_clear),
        .tick  (tick),
        .limit (TW'(TRAVEL_TICKS)),
        .done  (travel_done)
    );

    tick_timer #(.W(TW)) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .clear (door_clear),
        .tick  (tick),
        .limit (TW'(DOOR_TICKS)),
        .done  (door_done)
    );

    assign above = any_above(pending_q, cur_floor_q);
    assign below = any_below(pending_q, cur_floor_q);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_floor_d  = cur_floor_q;
        clr_mask     = '0;
        travel_clear = 1'b1;
        door_clear   = 1'b1;

        case (state_q)
            IDLE: begin
                if (pending_q[cur_floor_q]) begin
                    state_d               = DOOR_OPEN;
                    clr_mask[cur_floor_q] = 1'b1;
                end else if (above || below) begin
                    state_d = MOVING;
                    if (dir_q == UP) dir_d = above ? UP : DOWN;
                    else             dir_d = below ? DOWN : UP;
                end
            end
            MOVING: begin
                travel_clear = 1'b0;
                if (travel_done) begin
                    cur_floor_d = (dir_q == UP) ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;
                    // Stop decision uses the registered calls, so a call landing now waits.
                    if (pending_q[cur_floor_d]) begin
                        state_d               = DOOR_OPEN;
                        clr_mask[cur_floor_d] = 1'b1;
                    end else if ((dir_q == UP)   && !any_above(pending_q, cur_floor_d)) begin
                        state_d = IDLE;
                    end else if ((dir_q == DOWN) && !any_below(pending_q, cur_floor_d)) begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                door_clear = 1'b0;
                if (call_req[cur_floor_q]) begin
                    clr_mask[cur_floor_q] = 1'b1;
                    door_clear            = 1'b1;
                end else if (door_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | call_req) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= UP;
            cur_floor_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
        end
    end

    assign cur_floor   = cur_floor_q;
    assign pending     = pending_q;
    assign moving_up   = (state_q == MOVING) && (dir_q == UP);
    assign moving_down = (state_q == MOVING) && (dir_q == DOWN);
    assign door_open   = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - directed scenario bench for elevator_scheduler
module tb_elevator_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] call_req;
    logic [1:0] cur_floor;
    logic       moving_up, moving_down, door_open;
    logic [3:0] pending;
    logic [8:0] status;

    int checks;
    int failures;

    elevator_scheduler #(
        .NUM_FLOORS   (4),
        .TRAVEL_TICKS (3),
        .DOOR_TICKS   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .call_req    (call_req),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign status = {cur_floor, moving_up, moving_down, door_open, pending};

    function automatic logic [8:0] st(input int fl, input bit mu, input bit md, input bit dr, input logic [3:0] p);
        logic [1:0] f2;
        f2 = 2'(fl);
        return {f2, mu, md, dr, p};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        call_req = v;
        step(1);
        call_req = 4'b0;
    endtask

    task automatic do_reset();
        tick     = 1'b1;
        call_req = 4'b0;
        reset    = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; call_req = 4'b0;
        step(2);
        checks++;
        if (status !== 9'd0) begin failures++; $display("FAIL reset_state got=%h exp=%h", status, 9'd0); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (status !== 9'd0) begin failures++; $display("FAIL reset_idle_%0d got=%h exp=%h", i, status, 9'd0); end
        end
    endtask

    task automatic test_same_floor();
        pulse(4'b0001);
        checks++;
        if (status !== st(0,0,0,0,4'b0001)) begin failures++; $display("FAIL same_latch got=%h exp=%h", status, st(0,0,0,0,4'b0001)); end
        step(1);
        checks++;
        if (status !== st(0,0,0,1,4'b0000)) begin failures++; $display("FAIL same_open got=%h exp=%h", status, st(0,0,0,1,4'b0000)); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (status !== st(0,0,0,1,4'b0000)) begin failures++; $display("FAIL same_dwell_%0d got=%h exp=%h", i, status, st(0,0,0,1,4'b0000)); end
        end
        step(1);
        checks++;
        if (status !== st(0,0,0,0,4'b0000)) begin failures++; $display("FAIL same_close got=%h exp=%h", status, st(0,0,0,0,4'b0000)); end
    endtask

    task automatic test_travel_up();
        pulse(4'b0100);
        step(1);
        checks++;
        if (status !== st(0,1,0,0,4'b0100)) begin failures++; $display("FAIL up_start got=%h exp=%h", status, st(0,1,0,0,4'b0100)); end
        step(2);
        checks++;
        if (status !== st(0,1,0,0,4'b0100)) begin failures++; $display("FAIL up_mid0 got=%h exp=%h", status, st(0,1,0,0,4'b0100)); end
        step(1);
        checks++;
        if (status !== st(1,1,0,0,4'b0100)) begin failures++; $display("FAIL up_pass1 got=%h exp=%h", status, st(1,1,0,0,4'b0100)); end
        step(3);
        checks++;
        if (status !== st(2,0,0,1,4'b0000)) begin failures++; $display("FAIL up_arrive2 got=%h exp=%h", status, st(2,0,0,1,4'b0000)); end
        step(5);
        checks++;
        if (status !== st(2,0,0,0,4'b0000)) begin failures++; $display("FAIL up_idle2 got=%h exp=%h", status, st(2,0,0,0,4'b0000)); end
    endtask

    task automatic test_scan();
        do_reset();
        pulse(4'b1000);
        step(1);
        pulse(4'b1001);
        checks++;
        if (status !== st(0,1,0,0,4'b1001)) begin failures++; $display("FAIL scan_latch got=%h exp=%h", status, st(0,1,0,0,4'b1001)); end
        step(5);
        checks++;
        if (status !== st(2,1,0,0,4'b1001)) begin failures++; $display("FAIL scan_pass2 got=%h exp=%h", status, st(2,1,0,0,4'b1001)); end
        step(3);
        checks++;
        if (status !== st(3,0,0,1,4'b0001)) begin failures++; $display("FAIL scan_top got=%h exp=%h", status, st(3,0,0,1,4'b0001)); end
        step(5);
        checks++;
        if (status !== st(3,0,0,0,4'b0001)) begin failures++; $display("FAIL scan_idle3 got=%h exp=%h", status, st(3,0,0,0,4'b0001)); end
        step(1);
        checks++;
        if (status !== st(3,0,1,0,4'b0001)) begin failures++; $display("FAIL scan_reverse got=%h exp=%h", status, st(3,0,1,0,4'b0001)); end
        step(3);
        checks++;
        if (status !== st(2,0,1,0,4'b0001)) begin failures++; $display("FAIL scan_down2 got=%h exp=%h", status, st(2,0,1,0,4'b0001)); end
        step(6);
        checks++;
        if (status !== st(0,0,0,1,4'b0000)) begin failures++; $display("FAIL scan_bottom got=%h exp=%h", status, st(0,0,0,1,4'b0000)); end
        step(5);
        checks++;
        if (status !== st(0,0,0,0,4'b0000)) begin failures++; $display("FAIL scan_done got=%h exp=%h", status, st(0,0,0,0,4'b0000)); end
    endtask

    task automatic test_arrival_call();
        do_reset();
        pulse(4'b1000);
        step(3);
        pulse(4'b0010);
        checks++;
        if (status !== st(1,1,0,0,4'b1010)) begin failures++; $display("FAIL arrive_skip got=%h exp=%h", status, st(1,1,0,0,4'b1010)); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        pulse(4'b1000);
        step(8);
        checks++;
        if (status !== st(2,1,0,0,4'b1000)) begin failures++; $display("FAIL midrst_pre got=%h exp=%h", status, st(2,1,0,0,4'b1000)); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (status !== 9'd0) begin failures++; $display("FAIL midrst_async got=%h exp=%h", status, 9'd0); end
        step(1);
        reset = 1'b0;
        step(2);
        checks++;
        if (status !== 9'd0) begin failures++; $display("FAIL midrst_after got=%h exp=%h", status, 9'd0); end
    endtask

    task automatic test_tick_hold();
        do_reset();
        pulse(4'b0001);
        step(1);
        tick = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            checks++;
            if (door_open !== 1'b1) begin failures++; $display("FAIL hold_%0d got=%b exp=1", i, door_open); end
        end
        tick = 1'b1;
        step(4);
        checks++;
        if (door_open !== 1'b1) begin failures++; $display("FAIL hold_resume_open got=%b exp=1", door_open); end
        step(1);
        checks++;
        if (status !== 9'd0) begin failures++; $display("FAIL hold_resume_close got=%h exp=%h", status, 9'd0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(4'b0001);
        step(3);
        pulse(4'b0001);
        checks++;
        if (status !== st(0,0,0,1,4'b0000)) begin failures++; $display("FAIL b2b_restart got=%h exp=%h", status, st(0,0,0,1,4'b0000)); end
        step(4);
        checks++;
        if (door_open !== 1'b1) begin failures++; $display("FAIL b2b_still_open got=%b exp=1", door_open); end
        step(1);
        checks++;
        if (status !== 9'd0) begin failures++; $display("FAIL b2b_close got=%h exp=%h", status, 9'd0); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        tick     = 1'b1;
        call_req = 4'b0;
        test_reset();
        test_same_floor();
        test_travel_up();
        test_scan();
        test_arrival_call();
        test_reset_mid_move();
        test_tick_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
